exu_stage_ctrl: RTL
===================

# exu_stage_ctrl

Pipeline-stage controller that sequences the combinational `exu` between the decode stage (IDU) and the load/store stage. It accepts decoded operations over a valid/ready handshake, holds operands stable on the `exu` input ports, and captures `o_exu_res` into an output register. It also converts branch compare results into a one-cycle PC redirect, and handles flush and back-pressure.

## Interface
Parameters:
- `RD_W`, 5: destination register index width.

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_pre_valid`  in  1  IDU offers an operation.
- `o_pre_ready`  out  1  controller accepts an operation this cycle.
- `i_pc`, `i_rs1`, `i_rs2`, `i_imm`  in  `CPU_WIDTH` each  decoded operands.
- `i_src_sel`  in  `EXU_SEL_WIDTH`  operand select.
- `i_opt`  in  `EXU_OPT_WIDTH`  operation.
- `i_brch`  in  1  operation is a conditional branch (`EXU_BEQ`..`EXU_BGEU`).
- `i_rd`  in  `RD_W`  destination index.
- `i_rdwen`  in  1  destination write enable.
- `o_exu_pc`, `o_exu_rs1`, `o_exu_rs2`, `o_exu_imm`  out  `CPU_WIDTH`  drive the `exu` inputs.
- `o_exu_src_sel`, `o_exu_opt`  out  selector widths  drive the `exu` inputs.
- `i_exu_res`  in  `CPU_WIDTH`  `exu` result.
- `i_exu_zero`  in  1  `exu` zero flag.
- `o_post_valid`  out  1  result register holds a valid operation.
- `i_post_ready`  in  1  downstream accepts.
- `o_res`, `o_pc`  out  `CPU_WIDTH`  registered result and PC.
- `o_rd`  out  `RD_W`  registered destination index.
- `o_rdwen`  out  1  registered destination write enable; forced to 0 for branches.
- `o_redirect`  out  1  one-cycle pulse: taken branch.
- `o_redirect_pc`  out  `CPU_WIDTH`  branch target `pc + imm`, modulo 2^`CPU_WIDTH`.
- `i_flush`  in  1  kill all in-flight operations.

## Operation
- A transfer occurs on any edge where valid && ready. Data is held stable while valid && !ready.
- Result stage (B): `b_valid`, plus registered res/pc/rd/rdwen/brch/target. B loads when `b_valid==0 || i_post_ready`.
- Branch taken when `i_exu_zero==0`, i.e. `exu` bit 0 is 1. This is captured into B as `b_taken`.
- `o_redirect = b_valid && b_brch && b_taken && b_first`. `b_first` is set on B load and cleared after one cycle, so the redirect pulses once even if B stalls.
- Redirect cycle: `o_pre_ready` is forced to 0, and any operand-stage (A) entry is invalidated at the edge as wrong-path.
- `i_flush` has priority over all events. At the next edge, `a_valid` and `b_valid` clear, `b_first` clears, and no load occurs. `o_pre_ready` is 0 while `i_flush` is high. `o_redirect` is masked while `i_flush` is high.
- Simultaneous B drain and A→B move in the same cycle is legal and sustains full throughput.

Reset values:
- All valid bits, `b_first`, `o_post_valid` and `o_redirect` are 0.
- Data registers are 0.
- Reset asserted mid-operation discards everything immediately (asynchronous).

## Timing
- Throughput is 1 operation per cycle when `i_post_ready` is held high.
- Latency without `EXU_RETIME_EN`: accepted at edge N → `o_post_valid` at N+1.
- Latency with `EXU_RETIME_EN`: accepted at edge N → `o_post_valid` at N+2.
- `o_redirect` is asserted in the first cycle `o_post_valid` is high for a taken branch.
- Back-pressure propagates combinationally to `o_pre_ready` in the same cycle. `o_pre_ready` does not depend on `i_pre_valid`.

## Configuration
`EXU_RETIME_EN`:
- **Defined:** an operand register stage A (`a_valid` plus all operand fields) sits before `exu`, and `o_exu_*` are driven from A.
  - A loads when `!a_valid || B loads`.
  - `o_pre_ready = !i_flush && !o_redirect && (!a_valid || !b_valid || i_post_ready)`.
- **Undefined:** `o_exu_*` are driven combinationally from `i_*`, and B loads directly on the input transfer.
  - `o_pre_ready = !i_flush && !o_redirect && (!b_valid || i_post_ready)`.

## Test plan
- **ALU add, no stall:** `i_opt=ALU_ADD`, `src_sel=EXU_SEL_REG`, rs1=5, rs2=7, rd=3, `i_post_ready=1` → `o_res=12`, `o_rd=3`, `o_rdwen=1`, `o_post_valid` for exactly 1 cycle after latency 1 (2 with retime).
- **Taken branch:** `EXU_BEQ`, rs1=rs2=9, pc=0x8000_0000, imm=0x10 → `o_redirect` for 1 cycle, `o_redirect_pc=0x8000_0010`, `o_rdwen=0`, `o_pre_ready=0` in that cycle, and the following op is never presented downstream.
- **Not-taken branch with stall:** `EXU_BNE`, rs1=rs2=9, `i_post_ready=0` for 4 cycles → `o_redirect` never asserted, and B holds pc/res stable for all 4 cycles.
- **Stalled taken branch:** `EXU_BLT`, rs1=-1, rs2=1, `i_post_ready=0` for 3 cycles → exactly one `o_redirect` pulse, at B load.
- **Back-to-back stream:** 8 ops with `i_post_ready` toggling 1,0,1,0 → in-order delivery, no drops, no duplicates.
- **Flush and reset:** `i_flush` with A and B full → both valid bits 0 next cycle. `i_rst` pulse mid-stream → `o_post_valid=0` and `o_redirect=0` immediately, with no clock edge required.

Source files
------------

// File: rtl/exu_stage_ctrl_if.sv
// Handshake, operand and result bundle between IDU, exu_stage_ctrl, the combinational exu
// and the load/store stage. The slave modport is the controller's view.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef EXU_SEL_WIDTH
`define EXU_SEL_WIDTH 2
`endif
`ifndef EXU_OPT_WIDTH
`define EXU_OPT_WIDTH 4
`endif

interface exu_stage_ctrl_if #(
  parameter int RD_W = 5
);
  logic                      i_pre_valid;
  logic                      o_pre_ready;
  logic [`CPU_WIDTH-1:0]     i_pc;
  logic [`CPU_WIDTH-1:0]     i_rs1;
  logic [`CPU_WIDTH-1:0]     i_rs2;
  logic [`CPU_WIDTH-1:0]     i_imm;
  logic [`EXU_SEL_WIDTH-1:0] i_src_sel;
  logic [`EXU_OPT_WIDTH-1:0] i_opt;
  logic                      i_brch;
  logic [RD_W-1:0]           i_rd;
  logic                      i_rdwen;

  logic [`CPU_WIDTH-1:0]     o_exu_pc;
  logic [`CPU_WIDTH-1:0]     o_exu_rs1;
  logic [`CPU_WIDTH-1:0]     o_exu_rs2;
  logic [`CPU_WIDTH-1:0]     o_exu_imm;
  logic [`EXU_SEL_WIDTH-1:0] o_exu_src_sel;
  logic [`EXU_OPT_WIDTH-1:0] o_exu_opt;
  logic [`CPU_WIDTH-1:0]     i_exu_res;
  logic                      i_exu_zero;

  logic                      o_post_valid;
  logic                      i_post_ready;
  logic [`CPU_WIDTH-1:0]     o_res;
  logic [`CPU_WIDTH-1:0]     o_pc;
  logic [RD_W-1:0]           o_rd;
  logic                      o_rdwen;
  logic                      o_redirect;
  logic [`CPU_WIDTH-1:0]     o_redirect_pc;
  logic                      i_flush;

  modport slave (
    input  i_pre_valid, i_pc, i_rs1, i_rs2, i_imm, i_src_sel, i_opt, i_brch, i_rd, i_rdwen,
    input  i_exu_res, i_exu_zero, i_post_ready, i_flush,
    output o_pre_ready, o_exu_pc, o_exu_rs1, o_exu_rs2, o_exu_imm, o_exu_src_sel, o_exu_opt,
    output o_post_valid, o_res, o_pc, o_rd, o_rdwen, o_redirect, o_redirect_pc
  );

  modport master (
    output i_pre_valid, i_pc, i_rs1, i_rs2, i_imm, i_src_sel, i_opt, i_brch, i_rd, i_rdwen,
    output i_exu_res, i_exu_zero, i_post_ready, i_flush,
    input  o_pre_ready, o_exu_pc, o_exu_rs1, o_exu_rs2, o_exu_imm, o_exu_src_sel, o_exu_opt,
    input  o_post_valid, o_res, o_pc, o_rd, o_rdwen, o_redirect, o_redirect_pc
  );
endinterface

// File: rtl/exu_stage_ctrl.sv
// Execute-stage controller around the combinational exu: handshake, result register B,
// branch redirect and flush. Defining EXU_RETIME_EN adds operand register stage A.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef EXU_SEL_WIDTH
`define EXU_SEL_WIDTH 2
`endif
`ifndef EXU_OPT_WIDTH
`define EXU_OPT_WIDTH 4
`endif

module exu_stage_ctrl #(
  parameter int RD_W = 5
) (
  input  logic            i_clk,
  input  logic            i_rst,
  exu_stage_ctrl_if.slave bus
);
  localparam int W  = `CPU_WIDTH;
  localparam int SW = `EXU_SEL_WIDTH;
  localparam int OW = `EXU_OPT_WIDTH;

  typedef struct packed {
    logic [W-1:0]    pc;
    logic [W-1:0]    rs1;
    logic [W-1:0]    rs2;
    logic [W-1:0]    imm;
    logic [SW-1:0]   src_sel;
    logic [OW-1:0]   opt;
    logic            brch;
    logic [RD_W-1:0] rd;
    logic            rdwen;
  } op_t;

  typedef struct packed {
    logic [W-1:0]    res;
    logic [W-1:0]    pc;
    logic [W-1:0]    tgt;
    logic [RD_W-1:0] rd;
    logic            rdwen;
    logic            brch;
    logic            taken;
  } res_t;

  op_t  in_op_s;
  op_t  ex_op_s;
  res_t ex_res_s;
  logic ex_valid_s;
  logic b_load_s;
  logic redirect_s;
  logic pre_ready_s;
  logic in_xfer_s;

  logic b_valid_q, b_valid_d;
  logic b_first_q, b_first_d;
  res_t b_dat_q, b_dat_d;

  // Pack the decoded operation offered by the IDU.
  always_comb begin
    in_op_s.pc      = bus.i_pc;
    in_op_s.rs1     = bus.i_rs1;
    in_op_s.rs2     = bus.i_rs2;
    in_op_s.imm     = bus.i_imm;
    in_op_s.src_sel = bus.i_src_sel;
    in_op_s.opt     = bus.i_opt;
    in_op_s.brch    = bus.i_brch;
    in_op_s.rd      = bus.i_rd;
    in_op_s.rdwen   = bus.i_rdwen;
  end

  // B drain condition and the redirect pulse, which fires only in B's first valid cycle.
  always_comb begin
    b_load_s   = !b_valid_q || bus.i_post_ready;
    redirect_s = b_valid_q && b_dat_q.brch && b_dat_q.taken && b_first_q && !bus.i_flush;
  end

`ifdef EXU_RETIME_EN
  logic a_valid_q, a_valid_d;
  op_t  a_op_q, a_op_d;

  // A refills when empty or advancing into B; a redirect kills its wrong-path entry.
  always_comb begin
    pre_ready_s = !bus.i_flush && !redirect_s && (!a_valid_q || b_load_s);
    in_xfer_s   = bus.i_pre_valid && pre_ready_s;
    ex_op_s     = a_op_q;
    ex_valid_s  = a_valid_q && !redirect_s;
    a_valid_d   = a_valid_q;
    a_op_d      = a_op_q;
    if (bus.i_flush || redirect_s) begin
      a_valid_d = 1'b0;
    end else if (!a_valid_q || b_load_s) begin
      a_valid_d = in_xfer_s;
      a_op_d    = in_xfer_s ? in_op_s : a_op_q;
    end else begin
      a_valid_d = a_valid_q;
    end
  end

  // Operand register stage A.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_valid_q <= 1'b0;
      a_op_q    <= '0;
    end else begin
      a_valid_q <= a_valid_d;
      a_op_q    <= a_op_d;
    end
  end
`else
  // Without A the exu sees the IDU operands directly and B loads on the input transfer.
  always_comb begin
    pre_ready_s = !bus.i_flush && !redirect_s && b_load_s;
    in_xfer_s   = bus.i_pre_valid && pre_ready_s;
    ex_op_s     = in_op_s;
    ex_valid_s  = in_xfer_s;
  end
`endif

  // Result of the operation currently on the exu ports; branches never write rd.
  always_comb begin
    ex_res_s.res   = bus.i_exu_res;
    ex_res_s.pc    = ex_op_s.pc;
    ex_res_s.tgt   = ex_op_s.pc + ex_op_s.imm;
    ex_res_s.rd    = ex_op_s.rd;
    ex_res_s.rdwen = ex_op_s.rdwen & ~ex_op_s.brch;
    ex_res_s.brch  = ex_op_s.brch;
    ex_res_s.taken = ~bus.i_exu_zero;
  end

  // Next state of B; flush wins over any load.
  always_comb begin
    b_valid_d = b_valid_q;
    b_first_d = 1'b0;
    b_dat_d   = b_dat_q;
    if (bus.i_flush) begin
      b_valid_d = 1'b0;
      b_first_d = 1'b0;
    end else if (b_load_s) begin
      b_valid_d = ex_valid_s;
      b_first_d = ex_valid_s;
      b_dat_d   = ex_valid_s ? ex_res_s : b_dat_q;
    end else begin
      b_valid_d = b_valid_q;
      b_first_d = 1'b0;
    end
  end

  // Result register stage B.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      b_valid_q <= 1'b0;
      b_first_q <= 1'b0;
      b_dat_q   <= '0;
    end else begin
      b_valid_q <= b_valid_d;
      b_first_q <= b_first_d;
      b_dat_q   <= b_dat_d;
    end
  end

  // Output drive: exu operands from the active source, results straight from B.
  always_comb begin
    bus.o_pre_ready   = pre_ready_s;
    bus.o_exu_pc      = ex_op_s.pc;
    bus.o_exu_rs1     = ex_op_s.rs1;
    bus.o_exu_rs2     = ex_op_s.rs2;
    bus.o_exu_imm     = ex_op_s.imm;
    bus.o_exu_src_sel = ex_op_s.src_sel;
    bus.o_exu_opt     = ex_op_s.opt;
    bus.o_post_valid  = b_valid_q;
    bus.o_res         = b_dat_q.res;
    bus.o_pc          = b_dat_q.pc;
    bus.o_rd          = b_dat_q.rd;
    bus.o_rdwen       = b_dat_q.rdwen;
    bus.o_redirect    = redirect_s;
    bus.o_redirect_pc = b_dat_q.tgt;
  end
endmodule
